// File: rtl/spi_master.sv
// SPI mode 0 master: MSB first, one DATA_W-bit word per start/done handshake.
// cs_n can be held low across words to build multi-word frames.
module spi_master #(
    parameter int CLK_DIV = 4,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              hold_cs,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              sck,
    output logic              cs_n,
    output logic              mosi,
    input  logic              miso
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(DATA_W + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEAD   = 3'd1;
    localparam logic [2:0] S_SCK_HI = 3'd2;
    localparam logic [2:0] S_SCK_LO = 3'd3;
    localparam logic [2:0] S_TRAIL  = 3'd4;

    logic [2:0]        r_state;
    logic [DIV_W-1:0]  r_div;
    logic [BIT_W-1:0]  r_bits;
    logic [DATA_W-1:0] r_tx;
    logic [DATA_W-1:0] r_rx;
    logic [DATA_W-1:0] r_rx_data;
    logic              r_hold;
    logic              r_busy;
    logic              r_done;
    logic              r_sck;
    logic              r_cs_n;
    logic              r_mosi;

    logic              w_div_end;
    logic              w_last_bit;
    logic [DATA_W-1:0] w_tx_next;
    logic [DATA_W:0]   w_rx_ext;

    assign w_div_end  = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_last_bit = (r_bits == BIT_W'(DATA_W));
    assign w_tx_next  = r_tx << 1;
    assign w_rx_ext   = {r_rx, miso};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_div     <= '0;
            r_bits    <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_rx_data <= '0;
            r_hold    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sck     <= 1'b0;
            r_cs_n    <= 1'b1;
            r_mosi    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_div <= '0;
                    if (start) begin
                        r_tx    <= tx_data;
                        r_hold  <= hold_cs;
                        r_bits  <= '0;
                        r_busy  <= 1'b1;
                        r_cs_n  <= 1'b0;
                        r_mosi  <= tx_data[DATA_W-1];
                        r_state <= S_LEAD;
                    end
                end
                // LEAD and SCK_LO both end in a rising sck edge that samples miso
                S_LEAD, S_SCK_LO: begin
                    if (w_div_end) begin
                        r_div   <= '0;
                        r_sck   <= 1'b1;
                        r_rx    <= w_rx_ext[DATA_W-1:0];
                        r_bits  <= r_bits + 1'b1;
                        r_state <= S_SCK_HI;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                S_SCK_HI: begin
                    if (w_div_end) begin
                        r_div <= '0;
                        r_sck <= 1'b0;
                        if (w_last_bit) begin
                            r_state <= S_TRAIL;
                        end else begin
                            r_tx    <= w_tx_next;
                            r_mosi  <= w_tx_next[DATA_W-1];
                            r_state <= S_SCK_LO;
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                S_TRAIL: begin
                    if (w_div_end) begin
                        r_div     <= '0;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_rx_data <= r_rx;
                        r_cs_n    <= ~r_hold;
                        r_mosi    <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_div   <= '0;
                    r_busy  <= 1'b0;
                    r_sck   <= 1'b0;
                    r_cs_n  <= 1'b1;
                    r_mosi  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign rx_data = r_rx_data;
    assign sck     = r_sck;
    assign cs_n    = r_cs_n;
    assign mosi    = r_mosi;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: default divider with a constant-0xA5 slave
// or loopback, plus a second instance with CLK_DIV=1 in loopback.
module tb_spi_master;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] tx_data = '0;
    logic       hold_cs = 1'b0;
    logic       busy, done, sck, cs_n, mosi, miso;
    logic [7:0] rx_data;

    logic       start1 = 1'b0;
    logic [7:0] tx_data1 = '0;
    logic       busy1, done1, sck1, cs_n1, mosi1;
    logic [7:0] rx_data1;

    logic       loopback = 1'b0;
    logic [7:0] slave_word = 8'hA5;
    logic [2:0] slave_idx = 3'd7;
    logic       slave_miso;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    spi_master #(.CLK_DIV(4), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .tx_data(tx_data),
        .hold_cs(hold_cs), .busy(busy), .done(done), .rx_data(rx_data),
        .sck(sck), .cs_n(cs_n), .mosi(mosi), .miso(miso)
    );

    spi_master #(.CLK_DIV(1), .DATA_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .tx_data(tx_data1),
        .hold_cs(1'b0), .busy(busy1), .done(done1), .rx_data(rx_data1),
        .sck(sck1), .cs_n(cs_n1), .mosi(mosi1), .miso(mosi1)
    );

    // Dummy slave presents 0xA5 MSB first, shifting on each falling sck.
    always @(negedge sck or posedge cs_n) begin
        if (cs_n) slave_idx <= 3'd7;
        else      slave_idx <= slave_idx - 3'd1;
    end
    assign slave_miso = slave_word[slave_idx];
    assign miso = loopback ? mosi : slave_miso;

    // Called at a negedge; k=1 is the first negedge after the accepting posedge.
    task automatic do_xfer(input logic [7:0] tx, input logic hold, input int poke_k,
                           output int done_k, output logic [7:0] mbits, output int rises,
                           output int bad_hi, output int cs_hi, output logic [7:0] rx_d,
                           output logic cs_d, output logic busy_d);
        logic psck;
        int   hcnt;
        psck = 1'b0; hcnt = 0;
        done_k = -1; mbits = '0; rises = 0; bad_hi = 0; cs_hi = 0;
        rx_d = 'x; cs_d = 1'bx; busy_d = 1'bx;
        start = 1'b1; tx_data = tx; hold_cs = hold;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 2) begin tx_data = ~tx; hold_cs = ~hold; end
            if (k == poke_k) begin start = 1'b1; tx_data = 8'hFF; end
            if (k == poke_k + 1) start = 1'b0;
            if (sck) begin
                if (!psck) begin
                    rises++;
                    mbits = {mbits[6:0], mosi};
                    hcnt = 0;
                end
                hcnt++;
            end else if (psck && hcnt != 4) begin
                bad_hi++;
            end
            psck = sck;
            if (done) begin
                done_k = k; rx_d = rx_data; cs_d = cs_n; busy_d = busy;
                break;
            end
            if (cs_n) cs_hi++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({sck, cs_n, mosi, busy, done, rx_data} !== {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_outputs: got sck=%b cs_n=%b mosi=%b busy=%b done=%b rx=%h, want 0 1 0 0 0 00",
                     sck, cs_n, mosi, busy, done, rx_data);
        end
        n_cmp++;
        if ({sck1, cs_n1, busy1, done1} !== 4'b0100) begin
            n_fail++;
            $display("FAIL reset_div1: got sck=%b cs_n=%b busy=%b done=%b, want 0 1 0 0", sck1, cs_n1, busy1, done1);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int dk, r, bh, ch; logic [7:0] mb, rx; logic cd, bd;
        loopback = 1'b0;
        start = 1'b1; tx_data = 8'h3C; hold_cs = 1'b0;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if ({busy, cs_n, mosi} !== 3'b100) begin
            n_fail++;
            $display("FAIL basic_t0p1: got busy=%b cs_n=%b mosi=%b, want 1 0 0", busy, cs_n, mosi);
        end
        // Let it finish, then run the fully monitored transfer.
        repeat (80) @(negedge clk);
        do_xfer(8'h3C, 1'b0, -10, dk, mb, r, bh, ch, rx, cd, bd);
        n_cmp++;
        if (dk !== 69) begin n_fail++; $display("FAIL basic_done_cycle: got %0d want 69", dk); end
        n_cmp++;
        if (r !== 8) begin n_fail++; $display("FAIL basic_sck_pulses: got %0d want 8", r); end
        n_cmp++;
        if (bh !== 0) begin n_fail++; $display("FAIL basic_sck_high_len: %0d pulses not 4 cycles, want 0", bh); end
        n_cmp++;
        if (mb !== 8'h3C) begin n_fail++; $display("FAIL basic_mosi: got %h want 3c", mb); end
        n_cmp++;
        if (rx !== 8'hA5) begin n_fail++; $display("FAIL basic_rx: got %h want a5", rx); end
        n_cmp++;
        if ({cd, bd} !== 2'b10) begin n_fail++; $display("FAIL basic_done_cs_busy: got cs_n=%b busy=%b want 1 0", cd, bd); end
        n_cmp++;
        if (ch !== 0) begin n_fail++; $display("FAIL basic_cs_low: cs_n high %0d cycles during transfer, want 0", ch); end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got done=%b one cycle later, want 0", done); end
    endtask

    task automatic test_loopback();
        int dk, r, bh, ch; logic [7:0] mb, rx; logic cd, bd;
        loopback = 1'b1;
        do_xfer(8'h81, 1'b0, -10, dk, mb, r, bh, ch, rx, cd, bd);
        n_cmp++;
        if (rx !== 8'h81) begin n_fail++; $display("FAIL loop_81: got %h want 81", rx); end
        @(negedge clk);
        do_xfer(8'h5A, 1'b0, -10, dk, mb, r, bh, ch, rx, cd, bd);
        n_cmp++;
        if (rx !== 8'h5A) begin n_fail++; $display("FAIL loop_5a: got %h want 5a", rx); end
        loopback = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_held_frame();
        int dk1, r1, bh1, ch1, dk2, r2, bh2, ch2; logic [7:0] mb1, mb2, rx1, rx2; logic cd1, bd1, cd2, bd2;
        do_xfer(8'h12, 1'b1, -10, dk1, mb1, r1, bh1, ch1, rx1, cd1, bd1);
        do_xfer(8'h34, 1'b0, -10, dk2, mb2, r2, bh2, ch2, rx2, cd2, bd2);
        n_cmp++;
        if (cd1 !== 1'b0) begin n_fail++; $display("FAIL held_cs_first_done: got cs_n=%b want 0", cd1); end
        n_cmp++;
        if (ch1 + ch2 !== 0) begin n_fail++; $display("FAIL held_cs_continuous: cs_n high %0d cycles, want 0", ch1 + ch2); end
        n_cmp++;
        if (cd2 !== 1'b1) begin n_fail++; $display("FAIL held_cs_release: got cs_n=%b at second done, want 1", cd2); end
        n_cmp++;
        if (r1 + r2 !== 16) begin n_fail++; $display("FAIL held_sck_pulses: got %0d want 16", r1 + r2); end
        n_cmp++;
        if ({mb1, mb2} !== 16'h1234) begin n_fail++; $display("FAIL held_mosi: got %h%h want 1234", mb1, mb2); end
        n_cmp++;
        if (dk2 !== 69) begin n_fail++; $display("FAIL held_second_timing: got %0d want 69", dk2); end
        @(negedge clk);
    endtask

    task automatic test_start_while_busy();
        int dk, r, bh, ch, extra_done, extra_busy; logic [7:0] mb, rx; logic cd, bd;
        do_xfer(8'h00, 1'b0, 10, dk, mb, r, bh, ch, rx, cd, bd);
        n_cmp++;
        if (mb !== 8'h00) begin n_fail++; $display("FAIL busy_mosi: got %h want 00", mb); end
        n_cmp++;
        if (dk !== 69) begin n_fail++; $display("FAIL busy_timing: got %0d want 69", dk); end
        extra_done = 0; extra_busy = 0;
        repeat (80) begin
            @(negedge clk);
            if (done) extra_done++;
            if (busy) extra_busy++;
        end
        n_cmp++;
        if (extra_done + extra_busy !== 0) begin
            n_fail++;
            $display("FAIL busy_ignored: got %0d extra done, %0d busy cycles, want 0", extra_done, extra_busy);
        end
    endtask

    task automatic test_reset_mid();
        int dk, r, bh, ch, rises; logic [7:0] mb, rx; logic cd, bd, psck;
        rises = 0; psck = 1'b0;
        start = 1'b1; tx_data = 8'h96; hold_cs = 1'b1;
        for (int k = 1; k <= 100 && rises < 3; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (sck && !psck) rises++;
            psck = sck;
        end
        n_cmp++;
        if (rises !== 3) begin n_fail++; $display("FAIL rstmid_reach: got %0d rises want 3", rises); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_cmp++;
        if ({sck, cs_n, busy, done, rx_data} !== {1'b0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got sck=%b cs_n=%b busy=%b done=%b rx=%h want 0 1 0 0 00",
                     sck, cs_n, busy, done, rx_data);
        end
        do_xfer(8'h3C, 1'b0, -10, dk, mb, r, bh, ch, rx, cd, bd);
        n_cmp++;
        if ({dk, r, mb, rx, cd} !== {32'd69, 32'd8, 8'h3C, 8'hA5, 1'b1}) begin
            n_fail++;
            $display("FAIL rstmid_recover: got done_k=%0d rises=%0d mosi=%h rx=%h cs_n=%b want 69 8 3c a5 1",
                     dk, r, mb, rx, cd);
        end
        @(negedge clk);
    endtask

    task automatic test_clkdiv1();
        int dk, rises, bad_period, last_rise; logic psck;
        dk = -1; rises = 0; bad_period = 0; last_rise = 0; psck = 1'b0;
        start1 = 1'b1; tx_data1 = 8'hC3;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            start1 = 1'b0;
            if (sck1 && !psck) begin
                if (rises > 0 && k - last_rise != 2) bad_period++;
                rises++;
                last_rise = k;
            end
            psck = sck1;
            if (done1) begin dk = k; break; end
        end
        n_cmp++;
        if (dk !== 18) begin n_fail++; $display("FAIL div1_done_cycle: got %0d want 18", dk); end
        n_cmp++;
        if ({rises, bad_period} !== {32'd8, 32'd0}) begin
            n_fail++;
            $display("FAIL div1_sck: got %0d rises, %0d bad periods, want 8 0", rises, bad_period);
        end
        n_cmp++;
        if (rx_data1 !== 8'hC3) begin n_fail++; $display("FAIL div1_rx: got %h want c3", rx_data1); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_loopback();
        test_held_frame();
        test_start_while_busy();
        test_reset_mid();
        test_clkdiv1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Synthesizable SPI mode 0 (CPOL=0, CPHA=0) master; MSB first; one 8-bit word per transaction.
- Accepts a word over a start/busy/done handshake, drives sck/cs_n/mosi, and captures miso into rx_data.
- It is the initiator end of the SPI link. Benches pair it with the constant-0xA5 dummy slave model in tb/.

Parameters:
- CLK_DIV, 4, number of clk cycles per sck half-period; legal range is 1 or greater.
- DATA_W, 8, transfer word width in bits.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request a transfer; accepted only when busy=0.
- tx_data  input  DATA_W  word to send; sampled in the start-accept cycle.
- hold_cs  input  1  sampled with start; 1 keeps cs_n low after this word, for multi-word frames.
- busy  output  1  transfer in progress.
- done  output  1  one-cycle pulse at transfer completion.
- rx_data  output  DATA_W  word received on miso; updated in the done cycle.
- sck  output  1  SPI clock; idles low.
- cs_n  output  1  chip select, active low.
- mosi  output  1  serial data out.
- miso  input  1  serial data in.

Behaviour:
- Reset (rst_n=0 at a clk edge), from any state, including mid-transfer:
  - sck=0, cs_n=1, mosi=0, busy=0, done=0, rx_data=0.
  - FSM goes to IDLE; divider and bit counter clear; latched hold flag clears.
- States: IDLE, LEAD, SCK_HI, SCK_LO, TRAIL.
- IDLE: sck=0, busy=0. If start=1 at edge t0:
  - Latch tx_data into tx shift register and latch hold_cs.
  - At t0+1: busy=1, cs_n=0, mosi=tx_data[DATA_W-1]. Go to LEAD.
- LEAD: wait CLK_DIV cycles, then sck rises. Go to SCK_HI.
- Rising edge of sck: in the same clk cycle that sck goes 1, sample miso into rx shift register LSB. Shift left.
- SCK_HI: hold CLK_DIV cycles, then sck falls.
  - If bits remain: mosi updates to the next tx bit in the same cycle sck falls. Go to SCK_LO.
  - After the last bit: go to TRAIL instead; mosi holds the last bit.
- SCK_LO: hold CLK_DIV cycles, then sck rises. Go to SCK_HI.
- Bit counter counts rising edges. Exactly DATA_W rising edges per transaction; no extra sck pulse.
- TRAIL: hold CLK_DIV cycles. On exit, all in the same cycle:
  - done=1 for one cycle, busy=0, rx_data=rx shift register.
  - cs_n=1 unless the latched hold flag was 1, in which case cs_n stays 0.
  - mosi=0. Go to IDLE.
- Timing: done is asserted at cycle t0+1+(2*DATA_W+1)*CLK_DIV. This is cycle 69 for the defaults.
- The earliest next start is accepted in the done cycle+1, since busy is already 0 in the done cycle.
- Held cs_n: if cs_n is already low from a held frame, a new start behaves identically.
  - cs_n remains low (no glitch); mosi=new MSB at t0+1.
- cs_n is released only by completing a transaction with hold_cs=0. Reset also releases it.
- start while busy=1: ignored, with no effect on tx_data capture or timing. start is level-sampled only in IDLE.
- tx_data or hold_cs changing during busy: no effect.
- sck toggles only while cs_n=0. mosi is stable for at least CLK_DIV cycles before each sck rise and during sck high.
- CLK_DIV=1: sck period is 2 clk cycles; same state sequence, with every wait lasting one cycle.

Test Plan:
- Basic transfer, defaults, with tb/spi_slave_dummy:
  - Stimulus: tx_data=0x3C, hold_cs=0, start pulse at t0.
  - Required: cs_n falls at t0+1; exactly 8 sck pulses, each high 4 cycles; mosi bits sampled at sck rises = 0x3C.
  - Required: done single pulse at t0+69; rx_data=0xA5; cs_n=1 and busy=0 in the same cycle.
- Loopback (miso tied to mosi):
  - Stimulus: tx_data=0x81, then 0x5A.
  - Required: rx_data=0x81, then 0x5A.
- Held frame:
  - Stimulus: start 0x12 with hold_cs=1; start 0x34 with hold_cs=0 in the done cycle+1.
  - Required: cs_n stays 0 continuously through both words and rises only at the second done.
  - Required: 16 sck pulses total; mosi stream equals 0x12 then 0x34.
- Start while busy:
  - Stimulus: start with tx_data=0xFF at t0+10 during a 0x00 transfer.
  - Required: that request is ignored; mosi stays 0 for all 8 bits; only one done pulse.
- Reset mid-transfer:
  - Stimulus: rst_n=0 for 1 cycle after the 3rd sck rise.
  - Required: at the next edge sck=0, cs_n=1, busy=0, done=0, rx_data=0x00.
  - Required: a new start afterwards completes normally with full timing.
- CLK_DIV=1:
  - Stimulus: tx_data=0xC3, loopback.
  - Required: sck period 2 cycles; done at t0+18; rx_data=0xC3.
